// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_padder
// Purpose  : Byte-serial message padder. Builds padded 512-bit SHA-256 blocks
//            (0x80 marker, zero fill, 64-bit bit length) and flags each block
//            as first/last of its message. Optional block/message counters
//            are enabled with SHA256_PADDER_STATS_EN.
// Revision : 1.0
// ============================================================================
module sha256_padder #(
  parameter int LENW = 64,
  parameter int CNTW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       DIN,
  input  logic             DVALID,
  input  logic             DLAST,
  output logic             DREADY,
  output logic [511:0]     BLOCK,
  output logic             BVALID,
  input  logic             BREADY,
  output logic             BFIRST,
`ifdef SHA256_PADDER_STATS_EN
  output logic             BLAST,
  output logic [CNTW-1:0]  BLKCNT,
  output logic [CNTW-1:0]  MSGCNT
`else
  output logic             BLAST
`endif
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    LENBLK = 2'd2,
    EMIT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_PAD  = 2'd1,
    P_LEN  = 2'd2
  } pend_t;

  state_t           r_state, w_next;
  pend_t            r_pend;
  logic [5:0]       r_idx;
  logic [LENW-1:0]  r_len;
  logic [511:0]     r_block, w_wr_blk, w_pad_blk;
  logic             r_first, r_last;
  logic [63:0]      w_len64;
  logic             w_short;

  assign w_len64 = 64'(r_len);
  assign w_short = (r_idx <= 6'd55);

  assign DREADY = (r_state == FILL);
  assign BVALID = (r_state == EMIT);
  assign BLOCK  = r_block;
  assign BFIRST = r_first;
  assign BLAST  = r_last;

  // Byte 0 sits in the top byte lane, so lane i occupies [511-8i -: 8].
  always_comb begin
    w_wr_blk = r_block;
    for (int i = 0; i < 64; i++) begin
      if (r_idx == 6'(i)) w_wr_blk[511-8*i -: 8] = DIN;
    end
  end

  always_comb begin
    w_pad_blk = r_block;
    for (int i = 0; i < 64; i++) begin
      if (r_idx == 6'(i))     w_pad_blk[511-8*i -: 8] = 8'h80;
      else if (6'(i) > r_idx) w_pad_blk[511-8*i -: 8] = 8'h00;
    end
    if (w_short) w_pad_blk[63:0] = w_len64;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= FILL;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL: begin
        if (DVALID) begin
          if (r_idx == 6'd63) w_next = EMIT;
          else if (DLAST)     w_next = PAD;
        end
      end
      PAD:    w_next = EMIT;
      LENBLK: w_next = EMIT;
      EMIT: begin
        if (BREADY) begin
          case (r_pend)
            P_PAD:   w_next = PAD;
            P_LEN:   w_next = LENBLK;
            default: w_next = FILL;
          endcase
        end
      end
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx   <= 6'd0;
      r_len   <= '0;
      r_block <= '0;
      r_pend  <= P_NONE;
      r_first <= 1'b1;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (DVALID) begin
            r_block <= w_wr_blk;
            r_idx   <= r_idx + 6'd1;
            r_len   <= r_len + LENW'(8);
            if (r_idx == 6'd63) r_pend <= DLAST ? P_PAD : P_NONE;
          end
        end
        PAD: begin
          r_block <= w_pad_blk;
          r_last  <= w_short;
          r_pend  <= w_short ? P_NONE : P_LEN;
        end
        LENBLK: begin
          r_block <= {448'd0, w_len64};
          r_last  <= 1'b1;
          r_pend  <= P_NONE;
        end
        EMIT: begin
          if (BREADY) begin
            r_idx   <= 6'd0;
            r_block <= '0;
            r_last  <= 1'b0;
            // A completed message rearms BFIRST and restarts the bit count.
            r_first <= r_last;
            if (r_last) r_len <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_PADDER_STATS_EN
  logic [CNTW-1:0] r_blkcnt, r_msgcnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_blkcnt <= '0;
      r_msgcnt <= '0;
    end else if (BVALID && BREADY) begin
      if (r_blkcnt != '1)           r_blkcnt <= r_blkcnt + CNTW'(1);
      if (r_last && r_msgcnt != '1) r_msgcnt <= r_msgcnt + CNTW'(1);
    end
  end

  assign BLKCNT = r_blkcnt;
  assign MSGCNT = r_msgcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// Testbench for sha256_padder: directed messages, scoreboard of expected
// blocks drained by an independent monitor, plus latency/backpressure/reset checks.
module tb_sha256_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic [7:0]   DIN;
  logic         DVALID, DLAST, DREADY, BVALID, BREADY, BFIRST, BLAST;
  logic [511:0] BLOCK;
`ifdef SHA256_PADDER_STATS_EN
  logic [15:0]  BLKCNT, MSGCNT;
`endif

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  sha256_padder dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DVALID(DVALID), .DLAST(DLAST),
    .DREADY(DREADY), .BLOCK(BLOCK), .BVALID(BVALID), .BREADY(BREADY),
    .BFIRST(BFIRST),
`ifdef SHA256_PADDER_STATS_EN
    .BLAST(BLAST), .BLKCNT(BLKCNT), .MSGCNT(MSGCNT)
`else
    .BLAST(BLAST)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: a handshake completes on the posedge following a negedge that
  // sees BVALID & BREADY.
  always @(negedge CLK) begin
    if (!RST && BVALID && BREADY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_block: got %0h expected none", BLOCK);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("block", BLOCK, e.blk);
        chk("bfirst", 512'(BFIRST), 512'(e.first));
        chk("blast", 512'(BLAST), 512'(e.last));
      end
    end
  end

  task automatic push(input logic [511:0] blk, input logic first, input logic last);
    exp_t e;
    e.blk = blk; e.first = first; e.last = last;
    sb.push_back(e);
  endtask

  task automatic send_msg(input byte_q_t msg, input logic with_last);
    for (int i = 0; i < msg.size(); i++) begin
      int n = 0;
      while (!DREADY && n < 300) begin
        @(posedge CLK); #1;
        n++;
      end
      if (!DREADY) begin
        checks++; failures++;
        $display("FAIL dready_timeout: got 0 expected 1");
      end
      DIN    = msg[i];
      DVALID = 1'b1;
      DLAST  = with_last && (i == msg.size() - 1);
      @(posedge CLK); #1;
      DVALID = 1'b0;
      DLAST  = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t      m;
    logic [511:0] cap;
    logic         bad;
    int           n;

    RST = 1'b1; DIN = 8'h00; DVALID = 1'b0; DLAST = 1'b0; BREADY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_bvalid", 512'(BVALID), 512'd0);
    chk("rst_bfirst", 512'(BFIRST), 512'd1);
    chk("rst_blast",  512'(BLAST),  512'd0);
    chk("rst_block",  BLOCK,        512'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_dready", 512'(DREADY), 512'd1);

    // "test": PAD-terminated single block, BVALID two cycles after last byte
    push({32'h74657374, 8'h80, 408'd0, 64'h20}, 1'b1, 1'b1);
    m = '{8'h74, 8'h65, 8'h73, 8'h74};
    send_msg(m, 1'b1);
    chk("lat_pad_c1", 512'(BVALID), 512'd0);
    @(posedge CLK); #1;
    chk("lat_pad_c2", 512'(BVALID), 512'd1);
    drain();

    // "HDL" then "SHA256", back to back
    push({24'h48444C, 8'h80, 416'd0, 64'h18}, 1'b1, 1'b1);
    push({48'h534841323536, 8'h80, 392'd0, 64'h30}, 1'b1, 1'b1);
    m = '{8'h48, 8'h44, 8'h4C};
    send_msg(m, 1'b1);
    m = '{8'h53, 8'h48, 8'h41, 8'h32, 8'h35, 8'h36};
    send_msg(m, 1'b1);
    drain();

    // 56 bytes: length spills into a second block
    push({{56{8'h61}}, 8'h80, 56'd0}, 1'b1, 1'b0);
    push({448'd0, 64'h1C0}, 1'b0, 1'b1);
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h61);
    send_msg(m, 1'b1);
    drain();

    // 64 bytes: full data block, then a padding-only block
    push({64{8'h61}}, 1'b1, 1'b0);
    push({8'h80, 440'd0, 64'h200}, 1'b0, 1'b1);
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'h61);
    send_msg(m, 1'b1);
    chk("lat_full", 512'(BVALID), 512'd1);
    bad = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      if (DREADY) bad = 1'b1;
      @(posedge CLK); #1;
      n++;
    end
    chk("dready_low_64", 512'(bad), 512'd0);
    drain();

    // Backpressure
    BREADY = 1'b0;
    push({32'h74657374, 8'h80, 408'd0, 64'h20}, 1'b1, 1'b1);
    m = '{8'h74, 8'h65, 8'h73, 8'h74};
    send_msg(m, 1'b1);
    n = 0;
    while (!BVALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    cap = BLOCK;
    chk("bp_expected_block", cap, {32'h74657374, 8'h80, 408'd0, 64'h20});
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (!BVALID || BLOCK !== cap || DREADY) bad = 1'b1;
    end
    chk("bp_hold", 512'(bad), 512'd0);
    BREADY = 1'b1;
    @(posedge CLK); #1;
    chk("bp_drop", 512'(BVALID), 512'd0);
    chk("bp_single", 512'(sb.size()), 512'd0);

    // Reset mid-fill at IDX=10
    m = {};
    for (int i = 0; i < 10; i++) m.push_back(8'h55);
    send_msg(m, 1'b0);
    #2 RST = 1'b1;
    #1 chk("mid_rst_bvalid", 512'(BVALID), 512'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_dready", 512'(DREADY), 512'd1);
    chk("post_rst_bvalid", 512'(BVALID), 512'd0);
    chk("post_rst_bfirst", 512'(BFIRST), 512'd1);
    push({32'h74657374, 8'h80, 408'd0, 64'h20}, 1'b1, 1'b1);
    m = '{8'h74, 8'h65, 8'h73, 8'h74};
    send_msg(m, 1'b1);
    drain();

    chk("sb_empty", 512'(sb.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream feeder for the sha256 core.
- Accepts a message one byte per cycle and applies FIPS 180-4 padding: 0x80 marker, zero fill, and a 64-bit big-endian bit length.
- Emits complete 512-bit blocks in the format the core consumes on SHA512IN, with a valid/ready handshake.
- Per-block BFIRST/BLAST flags let the core-side controller reinitialise H and pulse START.

Parameters:
- LENW, 64, width of the internal bit-length counter; zero-extended into the 64-bit length field; wraps mod 2^LENW.
- CNTW, 16, width of the block statistics counter (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- DIN  in  8  message byte.
- DVALID  in  1  DIN valid.
- DLAST  in  1  qualifies DIN as the final byte of the message.
- DREADY  out  1  padder can accept a byte.
- BLOCK  out  512  padded block; byte 0 at [511:504], length field at [63:0].
- BVALID  out  1  BLOCK valid.
- BREADY  in  1  consumer takes BLOCK.
- BFIRST  out  1  BLOCK is the first block of a message.
- BLAST  out  1  BLOCK is the final block of a message.

Behaviour:
- Reset (asynchronous):
  - State FILL, IDX=0, bit-length counter=0, block register=0.
  - BVALID=0, BFIRST=1 (pending flag), BLAST=0.
  - DREADY=1 once RST is released.
- Byte accept:
  - Occurs on DVALID&DREADY; DREADY=1 only in state FILL (combinational from state).
  - The byte is written to block byte IDX; IDX increments; bit-length counter += 8.
- State FILL:
  - Accept at IDX<63 with DLAST=0: stay in FILL.
  - Accept at IDX=63 with DLAST=0: go to EMIT, pending=NONE.
  - Accept at IDX=63 with DLAST=1: go to EMIT, pending=PAD. The full data block is emitted with BLAST=0.
  - Accept at IDX<=62 with DLAST=1: go to PAD.
- State PAD (exactly 1 cycle):
  - Write 0x80 at byte IDX and zero all higher bytes.
  - If IDX<=55: write the length field, set BLAST, go to EMIT.
  - Else (IDX 56..63): go to EMIT with BLAST=0, pending=LEN.
- State LENBLK (1 cycle): block = zeros plus the length field; set BLAST; go to EMIT.
- State EMIT:
  - BVALID=1; BLOCK, BFIRST and BLAST are held stable until BREADY=1.
  - On the handshake: BVALID drops the next cycle; IDX=0; block register cleared.
  - Next state by pending: NONE→FILL, PAD→PAD (IDX=0), LEN→LENBLK.
  - If BLAST was 1: the length counter is cleared and BFIRST is set again for the next message. Otherwise BFIRST=0.
- Latency, from the accepting edge of the last byte:
  - BVALID rises 2 cycles later for a PAD-terminated block.
  - BVALID rises 1 cycle later for a full data block.
  - A LENBLK block follows its handshake by 2 cycles.
- Throughput: one byte/cycle in FILL. No byte is accepted in PAD, LENBLK or EMIT.
- Messages are at least 1 byte; a zero-length message is not supported.
- DLAST with DVALID=0 is ignored.
- A length counter overflow wraps silently.
- Reset mid-operation: the partial block and counter are discarded and BVALID drops immediately (asynchronously).

Optional Feature:
- Macro SHA256_PADDER_STATS_EN.
- Defined:
  - Adds output port BLKCNT [CNTW-1:0]: number of BVALID&BREADY handshakes since reset; saturates at all-ones; reset to 0.
  - Adds output port MSGCNT [CNTW-1:0]: count of handshakes with BLAST=1; saturates at all-ones; reset to 0.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Bytes 74 65 73 74 ("test"), BREADY=1:
  - One block 0x74657374_80, zeros, low 64 bits 0x20.
  - BFIRST=1, BLAST=1.
  - BVALID 2 cycles after the last byte.
- "HDL" (48 44 4C) then "SHA256":
  - Blocks 0x48444C80…0018, then 0x53484132353680…0030.
  - Each block has BFIRST=BLAST=1.
- 56 bytes of 0x61:
  - Block 1: 56x61, 80, 7 zero bytes; BFIRST=1, BLAST=0.
  - Block 2: all zero except length 0x1C0; BFIRST=0, BLAST=1.
- 64 bytes of 0x61:
  - Block 1: all 0x61, BLAST=0.
  - Block 2: 0x80 at byte 0, length 0x200, BLAST=1.
  - DREADY=0 throughout both blocks.
- Backpressure, "test" with BREADY low for 5 cycles:
  - BVALID held; BLOCK stable; DREADY=0.
  - Single handshake; BVALID drops the next cycle.
- RST pulsed while in FILL at IDX=10:
  - BVALID=0 and DREADY=1 after release.
  - Next "test" message produces the exact block of the first scenario, with BFIRST=1.
